// File: rtl/ama_pkg.sv
// Shared defaults and the result layout for the AMA4 adder error monitor.
package ama_pkg;

  // Default operand width and segmentation of the AMA4 ripple chain.
  localparam int unsigned AMA_WIDTH = 32;
  localparam int unsigned AMA_SEG_W = 4;
  localparam int unsigned AMA_CNT_W = 16;
  localparam int unsigned AMA_NSEG  = AMA_WIDTH / AMA_SEG_W;

  // Result bundle at the default geometry; the monitor builds the same layout at its own width.
  typedef struct packed {
    logic [AMA_WIDTH-1:0] sum;
    logic                 cout;
    logic [AMA_WIDTH+1:0] err;
    logic                 flag;
    logic [AMA_NSEG-1:0]  mask;
  } ama_res_t;

endpackage

// File: rtl/ama_pipe_slice.sv
// Single-entry valid/ready register slice. Full throughput: it reloads in the same cycle
// its contents leave. Data resets to zero so downstream outputs read 0 after reset.
module ama_pipe_slice #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic valid_q, valid_d;
  T     data_q, data_d;
  logic load;

  // Accept when empty or when the held entry is consumed this cycle.
  always_comb begin
    in_ready = !valid_q || out_ready;
    load     = in_valid && in_ready;
    valid_d  = load || (valid_q && !out_ready);
    data_d   = load ? in_data : data_q;
  end

  // Slice state; asynchronous reset drops any held entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/ama_err_monitor.sv
// Error monitor for the AMA4 approximate adder chain. Stage 1 captures the operands, the
// approximate result and the exact sum; stage 2 holds the signed error, the per-segment
// mismatch mask and the exact sum. Saturating statistics count delivered results.
module ama_err_monitor
  import ama_pkg::*;
#(
  parameter int unsigned WIDTH = AMA_WIDTH,
  parameter int unsigned SEG_W = AMA_SEG_W,
  parameter int unsigned CNT_W = AMA_CNT_W,
  localparam int unsigned NSEG = WIDTH / SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire              GND,
  inout  wire              Vdd,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] s_appr,
  input  logic             cout_appr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_exact,
  output logic             cout_exact,
  output logic [WIDTH+1:0] err_val,
  output logic             err_flag,
  output logic [NSEG-1:0]  seg_mask,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_err
);

  if ((WIDTH % SEG_W) != 0) begin : g_bad_geometry
    $error("ama_err_monitor: WIDTH must be a multiple of SEG_W");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s_appr;
    logic             cout_appr;
    logic [WIDTH:0]   exact;
  } stage1_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH+1:0] err;
    logic             flag;
    logic [NSEG-1:0]  mask;
  } res_t;

  stage1_t s1_in, s1_q;
  res_t    s2_in, s2_q;
  logic    s1_valid, s2_ready;
  logic [WIDTH+1:0] err_diff;

  logic [CNT_W-1:0] cnt_total_q, cnt_total_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;
  logic             res_hs;

  // Supply pins and the captured raw operands carry no logic downstream.
  logic unused_supply;
  logic unused_s1_ops;
  assign unused_supply = GND ^ Vdd;
  assign unused_s1_ops = ^{s1_q.a, s1_q.b, s1_q.cin};

  // Stage 1 payload: raw bundle plus the exact WIDTH+1-bit sum.
  always_comb begin
    s1_in           = '0;
    s1_in.a         = a;
    s1_in.b         = b;
    s1_in.cin       = cin;
    s1_in.s_appr    = s_appr;
    s1_in.cout_appr = cout_appr;
    s1_in.exact     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  end

  ama_pipe_slice #(
    .T(stage1_t)
  ) u_stage1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (s1_in),
    .out_valid(s1_valid),
    .out_ready(s2_ready),
    .out_data (s1_q)
  );

  // Stage 2 payload: {cout,sum} values are unsigned magnitudes, so they are widened with a
  // zero MSB before subtracting; the WIDTH+2 result is then an exact signed difference.
  always_comb begin
    err_diff   = {1'b0, s1_q.exact} - {1'b0, s1_q.cout_appr, s1_q.s_appr};
    s2_in      = '0;
    s2_in.sum  = s1_q.exact[WIDTH-1:0];
    s2_in.cout = s1_q.exact[WIDTH];
    s2_in.err  = err_diff;
    s2_in.flag = (err_diff != '0);
    for (int i = 0; i < NSEG; i++) begin
      s2_in.mask[i] = (s1_q.exact[i*SEG_W +: SEG_W] != s1_q.s_appr[i*SEG_W +: SEG_W]);
    end
  end

  ama_pipe_slice #(
    .T(res_t)
  ) u_stage2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s1_valid),
    .in_ready (s2_ready),
    .in_data  (s2_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (s2_q)
  );

  assign sum_exact  = s2_q.sum;
  assign cout_exact = s2_q.cout;
  assign err_val    = s2_q.err;
  assign err_flag   = s2_q.flag;
  assign seg_mask   = s2_q.mask;

  assign res_hs = out_valid && out_ready;

  // Statistics next state: clear dominates, otherwise saturating increments on delivery.
  always_comb begin
    cnt_total_d = cnt_total_q;
    cnt_err_d   = cnt_err_q;
    if (clr_stats) begin
      cnt_total_d = '0;
      cnt_err_d   = '0;
    end else if (res_hs) begin
      if (cnt_total_q != '1) begin
        cnt_total_d = cnt_total_q + CNT_W'(1);
      end
      if (s2_q.flag && (cnt_err_q != '1)) begin
        cnt_err_d = cnt_err_q + CNT_W'(1);
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_total_q <= '0;
      cnt_err_q   <= '0;
    end else begin
      cnt_total_q <= cnt_total_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

  assign cnt_total = cnt_total_q;
  assign cnt_err   = cnt_err_q;

endmodule

// File: tb/tb_ama_err_monitor.sv
// Directed bench for ama_err_monitor: a default instance and a CNT_W=4 instance share stimulus.
module tb_ama_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  wire         gnd_w;
  wire         vdd_w;
  logic        in_valid, out_ready, clr_stats;
  logic [31:0] a, b, s_appr;
  logic        cin, cout_appr;

  logic        in_ready, out_valid, cout_exact, err_flag;
  logic [31:0] sum_exact;
  logic [33:0] err_val;
  logic [7:0]  seg_mask;
  logic [15:0] cnt_total, cnt_err;

  logic        in_ready4, out_valid4, cout_exact4, err_flag4;
  logic [31:0] sum_exact4;
  logic [33:0] err_val4;
  logic [7:0]  seg_mask4;
  logic [3:0]  cnt_total4, cnt_err4;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_total, exp_err, exp_total4, exp_err4;
  int lat;

  assign gnd_w = 1'b0;
  assign vdd_w = 1'b1;

  always #5 clk = ~clk;

  ama_err_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .GND(gnd_w), .Vdd(vdd_w),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .s_appr(s_appr), .cout_appr(cout_appr), .out_valid(out_valid), .out_ready(out_ready),
    .sum_exact(sum_exact), .cout_exact(cout_exact), .err_val(err_val), .err_flag(err_flag),
    .seg_mask(seg_mask), .clr_stats(clr_stats), .cnt_total(cnt_total), .cnt_err(cnt_err)
  );

  ama_err_monitor #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .GND(gnd_w), .Vdd(vdd_w),
    .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b), .cin(cin),
    .s_appr(s_appr), .cout_appr(cout_appr), .out_valid(out_valid4), .out_ready(out_ready),
    .sum_exact(sum_exact4), .cout_exact(cout_exact4), .err_val(err_val4),
    .err_flag(err_flag4), .seg_mask(seg_mask4), .clr_stats(clr_stats),
    .cnt_total(cnt_total4), .cnt_err(cnt_err4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  task automatic check_cnt(input string tag);
    check_eq({tag, "_total"},  64'(cnt_total),  64'(exp_total));
    check_eq({tag, "_err"},    64'(cnt_err),    64'(exp_err));
    check_eq({tag, "_total4"}, 64'(cnt_total4), 64'(exp_total4));
    check_eq({tag, "_err4"},   64'(cnt_err4),   64'(exp_err4));
  endtask

  // Present one bundle at a negedge and hold it until accepted; returns just after that edge.
  task automatic send(input logic [31:0] ia, input logic [31:0] ib, input logic icin,
                      input logic [31:0] is, input logic ico);
    int n;
    @(negedge clk);
    a = ia; b = ib; cin = icin; s_appr = is; cout_appr = ico; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for a result (bounded), compare all fields, consume it with out_ready high.
  task automatic get_result(input string tag, input logic [31:0] es, input logic ec,
                            input logic [33:0] ee, input logic ef, input logic [7:0] em,
                            output int waited);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_sum"},   64'(sum_exact), 64'(es));
    check_eq({tag, "_cout"},  64'(cout_exact), 64'(ec));
    check_eq({tag, "_err"},   64'(err_val), 64'(ee));
    check_eq({tag, "_flag"},  64'(err_flag), 64'(ef));
    check_eq({tag, "_mask"},  64'(seg_mask), 64'(em));
    exp_total  = sat_inc(exp_total, 65535);
    exp_total4 = sat_inc(exp_total4, 15);
    if (ef) begin
      exp_err  = sat_inc(exp_err, 65535);
      exp_err4 = sat_inc(exp_err4, 15);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_stats = 1'b0;
    a = '0; b = '0; cin = 1'b0; s_appr = '0; cout_appr = 1'b0;
    exp_total = 0; exp_err = 0; exp_total4 = 0; exp_err4 = 0;

    // Reset state
    #12;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_sum", 64'(sum_exact), 64'd0);
    check_eq("rst_errval", 64'(err_val), 64'd0);
    check_cnt("rst_cnt");
    @(negedge clk);
    rst_n = 1'b1;

    // Exact result, two-cycle latency
    send(32'd5, 32'd3, 1'b0, 32'd8, 1'b0);
    @(negedge clk);
    check_eq("lat_early", 64'(out_valid), 64'd0);
    get_result("t2", 32'd8, 1'b0, 34'd0, 1'b0, 8'h00, lat);
    check_eq("lat_two", 64'(lat), 64'd0);
    @(negedge clk);
    check_cnt("t2_cnt");

    // Segments 0 and 1 both differ (0 vs 8, 1 vs 0)
    send(32'hF, 32'h1, 1'b0, 32'h8, 1'b0);
    get_result("t3", 32'h10, 1'b0, 34'd8, 1'b1, 8'h03, lat);

    // Full carry ripple the approximate chain missed
    send(32'hFFFF_FFFF, 32'h1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    get_result("t4", 32'h1, 1'b1, 34'd2, 1'b1, 8'hFF, lat);

    // Negative error of -1
    send(32'd1, 32'd1, 1'b0, 32'd3, 1'b0);
    get_result("neg", 32'd2, 1'b0, 34'h3_FFFF_FFFF, 1'b1, 8'h01, lat);

    // Spurious approximate carry-out: error without a segment mismatch
    send(32'd1, 32'd2, 1'b0, 32'd3, 1'b1);
    get_result("cout", 32'd3, 1'b0, 34'h3_0000_0000, 1'b1, 8'h00, lat);

    // Mismatch confined to segment 3
    send(32'h0F00, 32'h0100, 1'b0, 32'h0, 1'b0);
    get_result("seg3", 32'h1000, 1'b0, 34'h1000, 1'b1, 8'h08, lat);
    @(negedge clk);
    check_cnt("dir_cnt");

    // Backpressure: two accepted, then full; release yields both in order
    out_ready = 1'b0;
    a = 32'h10; b = 32'h20; cin = 1'b0; s_appr = 32'h30; cout_appr = 1'b0; in_valid = 1'b1;
    check_eq("bp_rdy_a", 64'(in_ready), 64'd1);
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; s_appr = 32'h2345_6780;
    check_eq("bp_rdy_b", 64'(in_ready), 64'd1);
    @(negedge clk);
    a = 32'hDEAD_0000; b = 32'h0000_BEEF; s_appr = 32'h0;
    check_eq("bp_full", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_hold_rdy", 64'(in_ready), 64'd0);
      check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
      check_eq("bp_hold_sum", 64'(sum_exact), 64'h30);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    get_result("bp_a", 32'h30, 1'b0, 34'd0, 1'b0, 8'h00, lat);
    get_result("bp_b", 32'h2345_6789, 1'b0, 34'd9, 1'b1, 8'h01, lat);
    @(negedge clk);
    check_eq("bp_drained", 64'(out_valid), 64'd0);
    check_cnt("bp_cnt");

    // Reset with two bundles in flight
    out_ready = 1'b0;
    a = 32'd7; b = 32'd7; s_appr = 32'd0; in_valid = 1'b1;
    @(negedge clk);
    a = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("mr_full", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_valid", 64'(out_valid), 64'd0);
    check_eq("mr_total", 64'(cnt_total), 64'd0);
    check_eq("mr_err", 64'(cnt_err), 64'd0);
    exp_total = 0; exp_err = 0; exp_total4 = 0; exp_err4 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("mr_rdy_next", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    check_eq("mr_no_stale", 64'(out_valid), 64'd0);

    // 20 erroneous results: 4-bit counters saturate at 15
    for (int i = 0; i < 20; i++) begin
      logic [31:0] v;
      v = 32'(i + 1);
      send(32'(i), 32'd1, 1'b0, 32'd0, 1'b0);
      get_result("sat", v, 1'b0, {2'b00, v}, 1'b1, {6'd0, v[7:4] != 4'd0, v[3:0] != 4'd0},
                 lat);
    end
    @(negedge clk);
    check_cnt("sat_cnt");
    check_eq("sat_err4_hold", 64'(cnt_err4), 64'd15);
    check_eq("sat_err16", 64'(cnt_err), 64'd20);

    // Clear coinciding with a handshake
    send(32'd1, 32'd1, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_eq("clr_valid", 64'(out_valid), 64'd1);
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    exp_total = 0; exp_err = 0; exp_total4 = 0; exp_err4 = 0;
    @(negedge clk);
    check_cnt("clr_cnt");
    check_eq("clr_drained", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
